// File: rtl/store_narrower.sv
// Store narrower: turns a 16-bit store into one or two 8-bit memory writes, flagging byte values outside signed 8-bit range.
// Optional feature macro STORE_SAT_EN: saturate out-of-range byte stores instead of truncating.
module store_narrower #(
  parameter int ADDR_W     = 8,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_data,
  input  logic              req_half,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              ovf,
  output logic              done,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        b0_q, b1_q;
  logic              half_q, ovf_q, done_q;
  logic              accept, fin, fits8;
  logic [7:0]        byte_val;

  // A byte fits when the upper byte is a pure sign extension of the lower one.
  assign fits8 = (req_data[15:8] == {8{req_data[7]}});

`ifdef STORE_SAT_EN
  assign byte_val = fits8 ? req_data[7:0] : (req_data[15] ? 8'h80 : 8'h7F);
`else
  assign byte_val = req_data[7:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst_n;
        accept    = req_valid & rst_n;
        if (accept) state_nxt = FIRST;
      end
      FIRST: begin
        mem_valid = 1'b1;
        busy      = 1'b1;
        if (mem_ready) begin
          state_nxt = half_q ? SECOND : IDLE;
          fin       = ~half_q;
        end
      end
      SECOND: begin
        mem_valid = 1'b1;
        busy      = 1'b1;
        if (mem_ready) begin
          state_nxt = IDLE;
          fin       = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Both payload bytes are resolved at capture so the memory side is a plain mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      b0_q   <= '0;
      b1_q   <= '0;
      half_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      ovf_q  <= accept & ~req_half & ~fits8;
      done_q <= fin;
      if (accept) begin
        addr_q <= req_addr;
        half_q <= req_half;
        if (req_half) begin
          b0_q <= BIG_ENDIAN ? req_data[15:8] : req_data[7:0];
          b1_q <= BIG_ENDIAN ? req_data[7:0]  : req_data[15:8];
        end else begin
          b0_q <= byte_val;
          b1_q <= 8'h00;
        end
      end
    end
  end

  assign mem_addr = (state == SECOND) ? addr_q + ADDR_W'(1) : addr_q;
  assign mem_data = (state == SECOND) ? b1_q : b0_q;
  assign ovf      = ovf_q;
  assign done     = done_q;

endmodule
